// File: rtl/guess_scorer.sv
// Serial Mastermind-style scorer: one exact pass, then one partial-match step per guess peg.
// Feedback digits come out sorted (exacts first), with counts, a win flag and a one-cycle result pulse.
module guess_scorer #(
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               guess_valid,
    output logic               guess_ready,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    input  logic [COLOR_W-1:0] code0,
    input  logic [COLOR_W-1:0] code1,
    input  logic [COLOR_W-1:0] code2,
    input  logic [COLOR_W-1:0] code3,
    output logic [1:0]         fb0,
    output logic [1:0]         fb1,
    output logic [1:0]         fb2,
    output logic [1:0]         fb3,
    output logic [2:0]         exact_cnt,
    output logic [2:0]         partial_cnt,
    output logic               result_valid,
    output logic               win
);

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXACT,
        S_PART0,
        S_PART1,
        S_PART2,
        S_PART3,
        S_PACK
    } state_t;

    state_t     state_q, state_d;
    color_t     guess_q [4];
    color_t     guess_d [4];
    color_t     code_q [4];
    color_t     code_d [4];
    logic [3:0] used_code_q, used_code_d;
    logic [3:0] used_guess_q, used_guess_d;
    logic [2:0] exact_n_q, exact_n_d;
    logic [2:0] partial_n_q, partial_n_d;
    logic [1:0] fb_q [4];
    logic [1:0] fb_d [4];
    logic [2:0] exact_cnt_q, exact_cnt_d;
    logic [2:0] partial_cnt_q, partial_cnt_d;
    logic       win_q, win_d;
    logic       result_valid_q, result_valid_d;

    logic [1:0] part_idx;
    state_t     part_next;
    color_t     part_color;
    logic       match_found;
    logic [1:0] match_idx;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

    function automatic logic [1:0] fb_digit(input logic [2:0] pos,
                                            input logic [2:0] e,
                                            input logic [2:0] p);
        if (pos < e) begin
            return 2'd2;
        end else if (pos < e + p) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    // Partial-match search for the peg selected by the current PARTk state.
    // Scanning downward lets the lowest free matching code index win.
    always_comb begin
        part_idx  = 2'd0;
        part_next = S_IDLE;
        unique case (state_q)
            S_PART0: begin part_idx = 2'd0; part_next = S_PART1; end
            S_PART1: begin part_idx = 2'd1; part_next = S_PART2; end
            S_PART2: begin part_idx = 2'd2; part_next = S_PART3; end
            S_PART3: begin part_idx = 2'd3; part_next = S_PACK;  end
            default: begin part_idx = 2'd0; part_next = S_IDLE;  end
        endcase
        part_color  = guess_q[part_idx];
        match_found = 1'b0;
        match_idx   = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (!used_code_q[j] && (code_q[j] == part_color)) begin
                match_found = 1'b1;
                match_idx   = 2'(j);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        guess_d        = guess_q;
        code_d         = code_q;
        used_code_d    = used_code_q;
        used_guess_d   = used_guess_q;
        exact_n_d      = exact_n_q;
        partial_n_d    = partial_n_q;
        fb_d           = fb_q;
        exact_cnt_d    = exact_cnt_q;
        partial_cnt_d  = partial_cnt_q;
        win_d          = win_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (guess_valid) begin
                    guess_d[0] = guess0;
                    guess_d[1] = guess1;
                    guess_d[2] = guess2;
                    guess_d[3] = guess3;
                    code_d[0]  = code0;
                    code_d[1]  = code1;
                    code_d[2]  = code2;
                    code_d[3]  = code3;
                    state_d    = S_EXACT;
                end
            end
            S_EXACT: begin
                for (int i = 0; i < 4; i++) begin
                    used_code_d[i]  = (guess_q[i] == code_q[i]);
                    used_guess_d[i] = (guess_q[i] == code_q[i]);
                end
                exact_n_d   = popcount4(used_code_d);
                partial_n_d = 3'd0;
                state_d     = S_PART0;
            end
            S_PART0, S_PART1, S_PART2, S_PART3: begin
                if (!used_guess_q[part_idx] && match_found) begin
                    used_code_d[match_idx] = 1'b1;
                    partial_n_d            = partial_n_q + 3'd1;
                end
                state_d = part_next;
            end
            S_PACK: begin
                for (int i = 0; i < 4; i++) begin
                    fb_d[i] = fb_digit(3'(i), exact_n_q, partial_n_q);
                end
                exact_cnt_d    = exact_n_q;
                partial_cnt_d  = partial_n_q;
                win_d          = (exact_n_q == 3'd4);
                result_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            guess_q        <= '{default: '0};
            code_q         <= '{default: '0};
            used_code_q    <= 4'd0;
            used_guess_q   <= 4'd0;
            exact_n_q      <= 3'd0;
            partial_n_q    <= 3'd0;
            fb_q           <= '{default: '0};
            exact_cnt_q    <= 3'd0;
            partial_cnt_q  <= 3'd0;
            win_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            guess_q        <= guess_d;
            code_q         <= code_d;
            used_code_q    <= used_code_d;
            used_guess_q   <= used_guess_d;
            exact_n_q      <= exact_n_d;
            partial_n_q    <= partial_n_d;
            fb_q           <= fb_d;
            exact_cnt_q    <= exact_cnt_d;
            partial_cnt_q  <= partial_cnt_d;
            win_q          <= win_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign guess_ready  = (state_q == S_IDLE);
    assign fb0          = fb_q[0];
    assign fb1          = fb_q[1];
    assign fb2          = fb_q[2];
    assign fb3          = fb_q[3];
    assign exact_cnt    = exact_cnt_q;
    assign partial_cnt  = partial_cnt_q;
    assign win          = win_q;
    assign result_valid = result_valid_q;

endmodule
